// File: rtl/seg_pkg.sv
// Shared constants, snapshot record and helpers for the 7-segment scan driver.
package seg_pkg;

  // Active-low segment patterns.
  localparam logic [6:0] SEG_BLANK   = 7'h7F;
  localparam logic [6:0] SEG_DASH    = 7'b0111111;

  // Widest supported digit-enable bus, all digits off (active-low).
  localparam int unsigned MAX_DIGITS = 8;
  localparam logic [MAX_DIGITS-1:0] SEG_DIG_OFF = '1;

  // Everything the output stage needs for one slot, frozen at slot start.
  typedef struct packed {
    logic [6:0] pattern;
    logic       dp;
    logic       blink;
    logic [3:0] bright;
  } slot_snap_t;

  localparam slot_snap_t SNAP_BLANK = '{
    pattern: SEG_BLANK,
    dp:      1'b0,
    blink:   1'b0,
    bright:  4'd0
  };

  // Slot index width: at least one bit even for tiny digit counts.
  function automatic int unsigned slot_width(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // A digit is lit while the PWM phase is within its duty level and it is
  // not being blanked by the blink phase.
  function automatic logic seg_lit(input logic [3:0] phase,
                                   input slot_snap_t snap,
                                   input logic blink_off);
    return (phase <= snap.bright) && !(blink_off && snap.blink);
  endfunction

endpackage

// File: rtl/seg_slot_timer.sv
// Scan timebase: slot prescaler, slot index, frame counter, blink phase and
// the end-of-frame pulse.
module seg_slot_timer
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SLOT_LOG2  = 16,
  parameter int unsigned BLINK_LOG2 = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                en,
  output logic                                pre_zero,
  output logic [3:0]                          phase,
  output logic [slot_width(NUM_DIGITS)-1:0]   slot,
  output logic                                blink_off,
  output logic                                frame_tick
);

  localparam int unsigned SLOT_W      = slot_width(NUM_DIGITS);
  localparam int unsigned FRM_W       = BLINK_LOG2 + 1;
  localparam int unsigned SLOT_LAST_I = NUM_DIGITS - 1;
  localparam int unsigned FRM_LAST_I  = (32'd1 << BLINK_LOG2) - 32'd1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_LAST_I[SLOT_W-1:0];
  localparam logic [FRM_W-1:0]  FRM_LAST  = FRM_LAST_I[FRM_W-1:0];

  logic [SLOT_LOG2-1:0] pre_q,   pre_d;
  logic [SLOT_W-1:0]    slot_q,  slot_d;
  logic [FRM_W-1:0]     frm_q,   frm_d;
  logic                 blink_q, blink_d;
  logic                 tick_q,  tick_d;
  logic                 pre_max;

  assign pre_max = &pre_q;

  // Next-state: prescaler wrap advances the slot, slot wrap closes a frame,
  // frame-counter wrap flips the blink phase; disable parks everything at 0.
  always_comb begin
    pre_d   = pre_q;
    slot_d  = slot_q;
    frm_d   = frm_q;
    blink_d = blink_q;
    tick_d  = 1'b0;
    if (!en) begin
      pre_d  = '0;
      slot_d = '0;
      frm_d  = '0;
    end else begin
      pre_d = pre_q + SLOT_LOG2'(1);
      if (pre_max) begin
        if (slot_q == SLOT_LAST) begin
          slot_d = '0;
          tick_d = 1'b1;
          if (frm_q == FRM_LAST) begin
            frm_d   = '0;
            blink_d = ~blink_q;
          end else begin
            frm_d = frm_q + FRM_W'(1);
          end
        end else begin
          slot_d = slot_q + SLOT_W'(1);
        end
      end
    end
  end

  // Timebase registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_q   <= '0;
      slot_q  <= '0;
      frm_q   <= '0;
      blink_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      slot_q  <= slot_d;
      frm_q   <= frm_d;
      blink_q <= blink_d;
      tick_q  <= tick_d;
    end
  end

  assign pre_zero   = (pre_q == '0);
  assign phase      = pre_q[SLOT_LOG2-1 -: 4];
  assign slot       = slot_q;
  assign blink_off  = blink_q;
  assign frame_tick = tick_q;

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver: per-slot input snapshot,
// brightness PWM, per-digit blink and registered pin outputs.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SLOT_LOG2  = 16,
  parameter int unsigned BLINK_LOG2 = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [7*NUM_DIGITS-1:0]   seg_in,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic [NUM_DIGITS-1:0]     blink_mask,
  input  logic [3:0]                brightness,
  output logic [NUM_DIGITS-1:0]     digit_sel,
  output logic [6:0]                display,
  output logic                      dp_out,
  output logic                      frame_tick
);

  localparam int unsigned SLOT_W = slot_width(NUM_DIGITS);

  if (NUM_DIGITS < 2 || NUM_DIGITS > MAX_DIGITS) begin : g_bad_digits
    $error("seg_scan_driver: NUM_DIGITS must be within 2..8");
  end
  if (SLOT_LOG2 < 4 || SLOT_LOG2 > 24) begin : g_bad_slot
    $error("seg_scan_driver: SLOT_LOG2 must be within 4..24");
  end
  if (BLINK_LOG2 > 12) begin : g_bad_blink
    $error("seg_scan_driver: BLINK_LOG2 must be within 0..12");
  end

  logic              pre_zero;
  logic [3:0]        phase;
  logic [SLOT_W-1:0] slot;
  logic              blink_off;

  seg_slot_timer #(
    .NUM_DIGITS (NUM_DIGITS),
    .SLOT_LOG2  (SLOT_LOG2),
    .BLINK_LOG2 (BLINK_LOG2)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .pre_zero   (pre_zero),
    .phase      (phase),
    .slot       (slot),
    .blink_off  (blink_off),
    .frame_tick (frame_tick)
  );

  slot_snap_t                live_snap;
  slot_snap_t                snap_q, snap_d;
  logic                      lit;
  logic [NUM_DIGITS-1:0]     digit_sel_q, digit_sel_d;
  logic [6:0]                display_q,   display_d;
  logic                      dp_q,        dp_d;

  // Select the live inputs belonging to the current slot.
  always_comb begin
    live_snap        = SNAP_BLANK;
    live_snap.bright = brightness;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (slot == SLOT_W'(k)) begin
        live_snap.pattern = seg_in[7*k +: 7];
        live_snap.dp      = dp_in[k];
        live_snap.blink   = blink_mask[k];
      end
    end
  end

  // The snapshot register only loads at slot start, but the output stage
  // reads snap_d so the first cycle of a slot already uses the fresh values
  // and the pin latency stays at exactly one cycle.
  always_comb begin
    snap_d = pre_zero ? live_snap : snap_q;
    lit    = en && seg_lit(phase, snap_d, blink_off);
  end

  // Pin values for the next cycle: one active-low digit when lit, blank otherwise.
  always_comb begin
    digit_sel_d = SEG_DIG_OFF[NUM_DIGITS-1:0];
    display_d   = SEG_BLANK;
    dp_d        = 1'b1;
    if (lit) begin
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
        if (slot == SLOT_W'(k)) begin
          digit_sel_d[k] = 1'b0;
        end
      end
      display_d = snap_d.pattern;
      dp_d      = ~snap_d.dp;
    end
  end

  // Snapshot and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      snap_q      <= SNAP_BLANK;
      digit_sel_q <= SEG_DIG_OFF[NUM_DIGITS-1:0];
      display_q   <= SEG_BLANK;
      dp_q        <= 1'b1;
    end else begin
      snap_q      <= snap_d;
      digit_sel_q <= digit_sel_d;
      display_q   <= display_d;
      dp_q        <= dp_d;
    end
  end

  assign digit_sel = digit_sel_q;
  assign display   = display_q;
  assign dp_out    = dp_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed self-checking bench for seg_scan_driver (4 digits, 16-cycle
// slots, blink phase toggling every 2 frames).
module tb_seg_scan_driver;

  localparam int unsigned ND = 4;
  localparam int unsigned SL = 4;
  localparam int unsigned BL = 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [7*ND-1:0] seg_in;
  logic [ND-1:0] dp_in;
  logic [ND-1:0] blink_mask;
  logic [3:0]    brightness;
  logic [ND-1:0] digit_sel;
  logic [6:0]    display;
  logic          dp_out;
  logic          frame_tick;

  int checks   = 0;
  int failures = 0;
  int t        = 0;   // cycles since the scan (re)started at slot 0, pre 0

  // What the bench expects to be on display per digit.
  logic [6:0] exp_pat [ND];
  logic [3:0] exp_bright;
  logic [3:0] exp_dp;
  logic [3:0] exp_mask;

  seg_scan_driver #(
    .NUM_DIGITS (ND),
    .SLOT_LOG2  (SL),
    .BLINK_LOG2 (BL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .seg_in     (seg_in),
    .dp_in      (dp_in),
    .blink_mask (blink_mask),
    .brightness (brightness),
    .digit_sel  (digit_sel),
    .display    (display),
    .dp_out     (dp_out),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
    end
  endtask

  task automatic chk_blank(input string tag);
    chk({tag, "_sel"},  {4'h0, digit_sel},  8'h0F);
    chk({tag, "_disp"}, {1'b0, display},    8'h7F);
    chk({tag, "_dp"},   {7'h0, dp_out},     8'h01);
    chk({tag, "_tick"}, {7'h0, frame_tick}, 8'h00);
  endtask

  // Advance n cycles, checking every pin against the hand-derived schedule:
  // 16-cycle slots, 64-cycle frames, blink-off during frames 2-3, 6-7, ...
  task automatic scan(input int n);
    for (int i = 0; i < n; i++) begin
      int         slot;
      int         pre;
      int         frame;
      logic       boff;
      logic       lit_e;
      logic [3:0] sel_e;
      logic [6:0] disp_e;
      logic       dp_e;
      logic       tick_e;
      tick();
      slot   = (t / 16) % 4;
      pre    = t % 16;
      frame  = t / 64;
      boff   = ((frame / 2) % 2) == 1;
      lit_e  = (pre <= int'(exp_bright)) && !(boff && exp_mask[slot]);
      sel_e  = lit_e ? ~(4'b0001 << slot) : 4'hF;
      disp_e = lit_e ? exp_pat[slot] : 7'h7F;
      dp_e   = lit_e ? ~exp_dp[slot] : 1'b1;
      tick_e = (slot == 3) && (pre == 15);
      chk("digit_sel",  {4'h0, digit_sel},  {4'h0, sel_e});
      chk("display",    {1'b0, display},    {1'b0, disp_e});
      chk("dp_out",     {7'h0, dp_out},     {7'h0, dp_e});
      chk("frame_tick", {7'h0, frame_tick}, {7'h0, tick_e});
      t++;
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    en         = 1'b1;
    seg_in     = {7'h10, 7'h00, 7'h24, 7'h79};
    dp_in      = 4'b0000;
    blink_mask = 4'b0000;
    brightness = 4'd15;
    exp_pat[0] = 7'h79;
    exp_pat[1] = 7'h24;
    exp_pat[2] = 7'h00;
    exp_pat[3] = 7'h10;
    exp_bright = 4'd15;
    exp_dp     = 4'b0000;
    exp_mask   = 4'b0000;

    // Reset held for three cycles.
    tick(); tick(); tick();
    chk_blank("reset");

    // Frame 0: full brightness scan, digit 0 appears one cycle after release.
    rst_n = 1'b1;
    t     = 0;
    scan(64);

    // Frame 1: brightness 3 lights each digit for pre 0..3 only.
    brightness = 4'd3;
    exp_bright = 4'd3;
    scan(64);

    // Frame 2: digit 0 input changes at pre 5 and must not show until frame 3.
    brightness = 4'd15;
    exp_bright = 4'd15;
    scan(5);
    seg_in[6:0] = 7'h40;
    scan(59);
    exp_pat[0] = 7'h40;
    scan(64);

    // Frames 4-7: digit 1 blinks (dark in frames 6-7), dp only on digit 0.
    blink_mask = 4'b0010;
    dp_in      = 4'b0001;
    exp_mask   = 4'b0010;
    exp_dp     = 4'b0001;
    scan(256);

    // Frame 8: drop enable at slot 2, pre 7; blank next cycle, no frame tick.
    scan(39);
    en = 1'b0;
    tick();
    chk_blank("en_drop");
    for (int i = 0; i < 49; i++) begin
      tick();
      chk_blank("en_low");
    end

    // Re-enable: scan restarts at digit 0 one cycle later.
    en = 1'b1;
    t  = 0;
    scan(176);

    // Reset at slot 3 of a blink-off frame; blink phase must restart lit.
    rst_n = 1'b0;
    tick();
    chk_blank("reset_mid");
    rst_n = 1'b1;
    t     = 0;
    scan(64);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Parametrised, time-multiplexed driver for common-anode 7-segment displays with N digits, an internal refresh prescaler, per-digit decimal points, per-digit blinking and 16-level brightness PWM. It sits between the digit-encoding logic (binary/BCD to active-low segment patterns) and the board pins. It replaces fixed 4-digit scanners that need an externally divided refresh clock: this block runs on the system clock and latches inputs once per slot, so the display never tears.

## Interface
- NUM_DIGITS, 4: number of digits scanned; legal range 2..8.
- SLOT_LOG2, 16: each digit slot lasts 2^SLOT_LOG2 clk cycles; legal range 4..24.
- BLINK_LOG2, 8: the blink phase toggles every 2^BLINK_LOG2 complete frames; legal range 0..12.
- clk  in  1  system clock.
- rst_n  in  1  reset: one clock, synchronous, active-low.
- en  in  1  scan enable; 0 blanks the display and holds the scan at slot 0.
- seg_in  in  7*NUM_DIGITS  active-low segment patterns; digit k is seg_in[7k+6:7k], bit 0 = segment a.
- dp_in  in  NUM_DIGITS  decimal point request per digit, active-high.
- blink_mask  in  NUM_DIGITS  1 = digit k blanks during the blink-off phase.
- brightness  in  4  duty level: digit is lit for (brightness+1)/16 of its slot.
- digit_sel  out  NUM_DIGITS  active-low digit enables; at most one bit is low.
- display  out  7  active-low segments.
- dp_out  out  1  active-low decimal point.
- frame_tick  out  1  one-cycle pulse at the end of every full scan.

## Operation
- State: prescaler pre[SLOT_LOG2-1:0], slot index slot[max(1,$clog2(NUM_DIGITS))-1:0], frame counter frm[BLINK_LOG2:0], blink_off bit, slot snapshot (pattern, dp, blink bit, brightness).
- Reset: pre=0, slot=0, frm=0, blink_off=0. digit_sel=all 1, display=7'h7F, dp_out=1, frame_tick=0.
- en=0: pre, slot and frm are forced to 0; blink_off holds its value. Outputs go blank (the reset values) on the next cycle.
- en=1: pre increments each cycle and wraps at 2^SLOT_LOG2-1. On the wrap, slot advances. Slot wraps from NUM_DIGITS-1 to 0, and that wrap increments frm and pulses frame_tick.
- When frm reaches 2^BLINK_LOG2-1 and the frame wraps, frm clears and blink_off toggles.
- Snapshot: on the cycle pre==0, the block captures seg_in, dp_in, blink_mask bit and brightness for the current slot. All input changes mid-slot are ignored until the next slot.
- Phase = pre[SLOT_LOG2-1:SLOT_LOG2-4]. The digit is lit when phase <= snapshot brightness, and not (blink_off and snapshot blink bit).
- Lit: digit_sel bit slot=0, all other bits 1; display = snapshot pattern; dp_out = ~snapshot dp.
- Unlit: digit_sel all 1, display 7'h7F, dp_out 1.
- Brightness 15 gives a 100% duty slot; brightness 0 gives 1/16.

## Timing
- All outputs are registered and reflect the state of the previous cycle, so latency is exactly 1 cycle from state to pin.
- After rst_n is released with en=1: on the first cycle pre=0 and slot 0 is snapshotted. The next cycle shows digit 0.
- Input change to pin: visible at the first slot start of that digit, plus 1 cycle.
- frame_tick is high on the cycle after slot NUM_DIGITS-1, pre=max. It falls in the same cycle digit 0 reappears.
- Enable rising edge: the scan restarts at slot 0, pre=0, with no partial slot.
- Enable falling edge mid-slot: the display is blank 1 cycle later and frame_tick does not fire.
- rst_n low mid-slot: outputs show the reset values at the next edge, regardless of en.
- Simultaneous slot wrap and frm wrap: frame_tick and the blink_off toggle take effect on the same edge.
- BLINK_LOG2=0: blink_off toggles every frame.

## Structure
- Shared package seg_pkg: SEG_BLANK=7'h7F, SEG_DASH=7'b0111111, SEG_DIG_OFF='1.
- Sub-module seg_slot_timer: prescaler, slot index, frame counter, blink_off and frame_tick. It exports pre_zero, phase[3:0], slot, blink_off and frame_tick.
- The top level holds the snapshot mux and the output registers.
- A NUM_DIGITS outside 2..8 or a SLOT_LOG2 below 4 is an elaboration error.

## Test plan
All scenarios use NUM_DIGITS=4, SLOT_LOG2=4, BLINK_LOG2=1.
- Reset then scan: rst_n low 3 cycles, en=1, seg_in={7'h10,7'h00,7'h24,7'h79}, brightness=15. The response is digit_sel=1110 with display=7'h79 for 16 cycles starting 1 cycle after release, then 1101/7'h24, 1011/7'h00, 0111/7'h10. frame_tick pulses every 64 cycles.
- PWM: brightness=3. Each digit is low for 4 of its 16 cycles (pre 0..3) and digit_sel=1111 for the remaining 12.
- Snapshot: change seg_in digit 0 to 7'h40 at pre=5 of slot 0. The pin keeps 7'h79 until slot 0 of the next frame, then shows 7'h40.
- Blink: blink_mask=0010 and dp_in=0001. Digit 1 is dark during frames 2-3, 6-7 and so on, while the other digits stay lit. dp_out=0 only during slot 0.
- Enable drop: en=0 at slot 2, pre=7. Next cycle digit_sel=1111, display=7'h7F, with no frame_tick. Re-enable resumes at digit 0, 1 cycle later.
- Reset mid-operation: rst_n=0 at slot 3. Next edge gives the reset values and blink_off=0.
